// File: rtl/ghost_mover_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ghost_mover_if                                                             |
// | Chase-logic requests and wall flags in, ghost position and status out.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ghost_mover_if;
  logic        frame_tick;
  logic        gU, gD, gL, gR;
  logic        g1uE, g1dE, g1lE, g1rE;
  logic        caught;
  logic [10:0] xGhost, yGhost;
  logic [3:0]  dir;
  logic [1:0]  state;
  logic        moving;

  modport master (
    output frame_tick, gU, gD, gL, gR, g1uE, g1dE, g1lE, g1rE, caught,
    input  xGhost, yGhost, dir, state, moving
  );

  modport slave (
    input  frame_tick, gU, gD, gL, gR, g1uE, g1dE, g1lE, g1rE, caught,
    output xGhost, yGhost, dir, state, moving
  );
endinterface
`default_nettype wire

// File: rtl/ghost_mover.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ghost_mover                                                                |
// | Ghost life-cycle (HOME/LEAVING/CHASE) and frame-paced position update.     |
// | Define GHOST_TUNNEL_WRAP_EN to wrap x across the tunnel instead of clamp.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ghost_mover #(
  parameter logic [10:0] X_START        = 11'd320,
  parameter logic [10:0] Y_START        = 11'd240,
  parameter logic [10:0] EXIT_Y         = 11'd208,
  parameter int          STEP           = 4,
  parameter int          MOVE_DIV       = 2,
  parameter int          RELEASE_FRAMES = 120,
  parameter logic [10:0] X_MIN          = 11'd0,
  parameter logic [10:0] X_MAX          = 11'd639
) (
  input wire logic     clk,
  input wire logic     reset,
  ghost_mover_if.slave bus
);
  typedef enum logic [1:0] {
    S_HOME    = 2'b00,
    S_LEAVING = 2'b01,
    S_CHASE   = 2'b10
  } state_t;

  localparam logic [3:0]  c_dir_u    = 4'b1000;
  localparam logic [3:0]  c_dir_d    = 4'b0100;
  localparam logic [3:0]  c_dir_l    = 4'b0010;
  localparam logic [3:0]  c_dir_r    = 4'b0001;
  localparam logic [11:0] c_step     = 12'(STEP);
  localparam logic [11:0] c_xmin     = {1'b0, X_MIN};
  localparam logic [11:0] c_xmax     = {1'b0, X_MAX};
  localparam logic [11:0] c_ymax     = 12'd2047;
  localparam logic [15:0] c_div_last = 16'(MOVE_DIV - 1);
  localparam logic [15:0] c_rel_last = 16'(RELEASE_FRAMES - 1);

  state_t      r_state, w_state_nx;
  logic [10:0] r_x, r_y, w_x_nx, w_y_nx;
  logic [10:0] w_xl, w_xr, w_yu, w_yd;
  logic [3:0]  r_dir, w_dir_nx, w_sel, w_en;
  logic [15:0] r_div, r_rel, w_div_nx, w_rel_nx;
  logic        w_tick, w_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HOME;
      r_x     <= X_START;
      r_y     <= Y_START;
      r_dir   <= 4'b0000;
      r_div   <= 16'd0;
      r_rel   <= 16'd0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_dir   <= w_dir_nx;
      r_div   <= w_div_nx;
      r_rel   <= w_rel_nx;
    end
  end

  always_comb begin
    w_tick = bus.frame_tick && (r_state != S_HOME) && (r_div == c_div_last);
    w_en   = {bus.g1uE, bus.g1dE, bus.g1lE, bus.g1rE};

    // Fresh requests win in R,L,D,U order; otherwise coast on the current dir.
    w_sel = 4'b0000;
    if (bus.gR && bus.g1rE)            w_sel = c_dir_r;
    else if (bus.gL && bus.g1lE)       w_sel = c_dir_l;
    else if (bus.gD && bus.g1dE)       w_sel = c_dir_d;
    else if (bus.gU && bus.g1uE)       w_sel = c_dir_u;
    else if ((r_dir & w_en) != 4'b0000) w_sel = r_dir;

`ifdef GHOST_TUNNEL_WRAP_EN
    if ({1'b0, r_x} < c_xmin + c_step) w_xl = 11'(c_xmax - c_step + 12'd1 + ({1'b0, r_x} - c_xmin));
    else                               w_xl = 11'({1'b0, r_x} - c_step);
    if ({1'b0, r_x} + c_step > c_xmax) w_xr = 11'(c_xmin + ({1'b0, r_x} + c_step - c_xmax - 12'd1));
    else                               w_xr = 11'({1'b0, r_x} + c_step);
    w_clr = 1'b0;
`else
    if ({1'b0, r_x} < c_xmin + c_step) w_xl = X_MIN;
    else                               w_xl = 11'({1'b0, r_x} - c_step);
    if ({1'b0, r_x} + c_step > c_xmax) w_xr = X_MAX;
    else                               w_xr = 11'({1'b0, r_x} + c_step);
    // A clamped horizontal move that goes nowhere stops the ghost.
    w_clr = ((w_sel == c_dir_r) && (w_xr == r_x)) || ((w_sel == c_dir_l) && (w_xl == r_x));
`endif
    if ({1'b0, r_y} < c_step)          w_yu = 11'd0;
    else                               w_yu = 11'({1'b0, r_y} - c_step);
    if ({1'b0, r_y} + c_step > c_ymax) w_yd = 11'(c_ymax);
    else                               w_yd = 11'({1'b0, r_y} + c_step);

    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_dir_nx   = r_dir;
    w_div_nx   = r_div;
    w_rel_nx   = r_rel;

    if (bus.caught) begin
      w_state_nx = S_HOME;
      w_x_nx     = X_START;
      w_y_nx     = Y_START;
      w_dir_nx   = 4'b0000;
      w_div_nx   = 16'd0;
      w_rel_nx   = 16'd0;
    end else if (r_state == S_HOME) begin
      if (bus.frame_tick) begin
        if (r_rel == c_rel_last) begin
          w_state_nx = S_LEAVING;
          w_rel_nx   = 16'd0;
        end else begin
          w_rel_nx   = r_rel + 16'd1;
        end
      end
    end else begin
      if (bus.frame_tick) w_div_nx = w_tick ? 16'd0 : r_div + 16'd1;
      if (w_tick) begin
        if (r_state == S_LEAVING) begin
          if (w_yu <= EXIT_Y) begin
            w_y_nx     = EXIT_Y;
            w_dir_nx   = 4'b0000;
            w_state_nx = S_CHASE;
          end else begin
            w_y_nx     = w_yu;
            w_dir_nx   = c_dir_u;
          end
        end else begin
          w_dir_nx = w_clr ? 4'b0000 : w_sel;
          case (w_sel)
            c_dir_r: w_x_nx = w_xr;
            c_dir_l: w_x_nx = w_xl;
            c_dir_d: w_y_nx = w_yd;
            c_dir_u: w_y_nx = w_yu;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.xGhost = r_x;
  assign bus.yGhost = r_y;
  assign bus.dir    = r_dir;
  assign bus.state  = r_state;
  assign bus.moving = |r_dir;
endmodule
`default_nettype wire

// File: tb/tb_ghost_mover.sv
`default_nettype none
// Bench for ghost_mover: three instances (MOVE_DIV 1/2, X_START 320/322) share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_ghost_mover;
  localparam int          c_div [3] = '{1, 2, 1};
  localparam logic [10:0] c_xs  [3] = '{11'd320, 11'd320, 11'd322};
  localparam int          c_dx  [4] = '{4, -4, 0, 0};   // index 0..3 = R,L,D,U
  localparam int          c_dy  [4] = '{0, 0, 4, -4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ft, cg, chk;
  logic [3:0] req, en;                 // {U,D,L,R}
  logic [10:0] ox [3], oy [3];
  logic [3:0]  od [3];
  logic [1:0]  os [3];
  logic        om [3];
  int checks = 0, failures = 0;
  int mx [3], my [3], md [3], ms [3], mdv [3], mrl [3];

  ghost_mover_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].frame_tick = ft;
    assign bus[g].caught     = cg;
    assign {bus[g].gU, bus[g].gD, bus[g].gL, bus[g].gR}         = req;
    assign {bus[g].g1uE, bus[g].g1dE, bus[g].g1lE, bus[g].g1rE} = en;
    assign ox[g] = bus[g].xGhost;
    assign oy[g] = bus[g].yGhost;
    assign od[g] = bus[g].dir;
    assign os[g] = bus[g].state;
    assign om[g] = bus[g].moving;
    ghost_mover #(.X_START(c_xs[g]), .MOVE_DIV(c_div[g]), .RELEASE_FRAMES(3)) u_dut (
      .clk(clk), .reset(rst), .bus(bus[g])
    );
  end

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  task automatic model_move(int i);
    int pick, nx, ny;
    if (ms[i] == 1) begin
      my[i] = (my[i] - 4 < 0) ? 0 : my[i] - 4;
      if (my[i] <= 208) begin my[i] = 208; md[i] = 0; ms[i] = 2; end
      else md[i] = 8;
    end else begin
      pick = -1;
      for (int k = 0; k < 4; k++) if (pick < 0 && req[k] && en[k]) pick = k;
      for (int k = 0; k < 4; k++) if (pick < 0 && md[i] == (1 << k) && en[k]) pick = k;
      if (pick < 0) md[i] = 0;
      else begin
        nx = mx[i] + c_dx[pick];
        ny = my[i] + c_dy[pick];
        md[i] = 1 << pick;
        if (ny < 0) ny = 0;
        if (ny > 2047) ny = 2047;
`ifdef GHOST_TUNNEL_WRAP_EN
        if (nx < 0) nx += 640;
        if (nx > 639) nx -= 640;
`else
        if (nx < 0) nx = 0;
        if (nx > 639) nx = 639;
        if (pick < 2 && nx == mx[i]) md[i] = 0;
`endif
        mx[i] = nx;
        my[i] = ny;
      end
    end
  endtask

  // Behavioural model: updated on the same edges the design sees.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || cg) begin
        mx[i] = int'(c_xs[i]); my[i] = 240; md[i] = 0; ms[i] = 0; mdv[i] = 0; mrl[i] = 0;
      end else if (ms[i] == 0) begin
        if (ft) begin
          mrl[i]++;
          if (mrl[i] == 3) begin ms[i] = 1; mrl[i] = 0; end
        end
      end else if (ft) begin
        mdv[i] = (mdv[i] + 1) % c_div[i];
        if (mdv[i] == 0) model_move(i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d.x", i),      int'(ox[i]), mx[i]);
        check($sformatf("dut%0d.y", i),      int'(oy[i]), my[i]);
        check($sformatf("dut%0d.dir", i),    int'(od[i]), md[i]);
        check($sformatf("dut%0d.state", i),  int'(os[i]), ms[i]);
        check($sformatf("dut%0d.moving", i), int'(om[i]), int'(md[i] != 0));
      end
    end
  end

  task automatic ftk(int n);
    repeat (n) begin
      @(negedge clk); ft = 1'b1;
      @(negedge clk); ft = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ft = 1'b0; cg = 1'b0; req = 4'b0; en = 4'b0; chk = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0; chk = 1'b1;
    @(negedge clk);
    check("reset_x", int'(ox[0]), 320);
    check("reset_y", int'(oy[0]), 240);
    check("reset_state", int'(os[0]), 0);
    check("reset_x_c", int'(ox[2]), 322);

    ftk(3);
    check("release_state", int'(os[0]), 1);
    ftk(8);
    check("exit_y", int'(oy[0]), 208);
    check("exit_state", int'(os[0]), 2);
    check("exit_dir", int'(od[0]), 0);
    check("leave_div2_y", int'(oy[1]), 224);
    ftk(8);
    check("exit_div2_y", int'(oy[1]), 208);
    check("exit_div2_state", int'(os[1]), 2);

    req = 4'b0001; en = 4'b0001;
    ftk(2); check("div2_x_t2", int'(ox[1]), 324);
    ftk(2); check("div2_x_t4", int'(ox[1]), 328);
    ftk(1); check("div2_x_t5", int'(ox[1]), 328);
    check("div2_dir", int'(od[1]), 1);
    check("div1_x_t5", int'(ox[0]), 340);

    req = 4'b0100; en = 4'b0001;
    ftk(1); check("keep_r_x", int'(ox[0]), 344);
    check("keep_r_dir", int'(od[0]), 1);
    req = 4'b0000; en = 4'b0000;
    ftk(1); check("stop_dir", int'(od[0]), 0);
    check("stop_x", int'(ox[0]), 344);
    check("stop_moving", int'(om[0]), 0);

    req = 4'b1001; en = 4'b1000;
    ftk(1); check("prio_u_dir", int'(od[0]), 8);
    check("prio_u_y", int'(oy[0]), 204);
    req = 4'b0110; en = 4'b1111;
    ftk(1); check("prio_l_dir", int'(od[0]), 2);

    for (int n = 0; n < 200 && mx[2] > 2; n++) ftk(1);
    check("tunnel_x_pre", int'(ox[2]), 2);
    ftk(1);
`ifdef GHOST_TUNNEL_WRAP_EN
    check("tunnel_wrap_x", int'(ox[2]), 638);
    check("tunnel_wrap_dir", int'(od[2]), 2);
`else
    check("tunnel_sat_x", int'(ox[2]), 0);
    check("tunnel_sat_dir", int'(od[2]), 2);
    ftk(1);
    check("tunnel_hold_x", int'(ox[2]), 0);
    check("tunnel_hold_dir", int'(od[2]), 0);
`endif

    req = 4'b0000;
    pulse_reset();
    ftk(3);
    ftk(5);
    check("leave_y220", int'(oy[0]), 220);
    @(negedge clk); ft = 1'b1; cg = 1'b1;
    @(negedge clk); ft = 1'b0; cg = 1'b0;
    check("caught_x", int'(ox[0]), 320);
    check("caught_y", int'(oy[0]), 240);
    check("caught_state", int'(os[0]), 0);
    ftk(2); check("caught_rel2", int'(os[0]), 0);
    ftk(1); check("caught_rel3", int'(os[0]), 1);
    ftk(1); check("caught_step", int'(oy[0]), 236);

    repeat (4000) begin
      @(negedge clk);
      ft  = 1'($urandom_range(0, 1));
      cg  = ($urandom_range(0, 99) == 0);
      req = 4'($urandom);
      en  = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
      end
    end
    @(negedge clk);
    chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
